regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port between two writeback requesters: A (ALU writeback) and B (load/memory writeback).
- Each requester gets a small FIFO. A round-robin arbiter drains one entry per cycle onto the register file's enwr/regNum/wrdata inputs.
- Sits between the execute/memory stages and the register file.
- Removes write-port conflicts without stalling both producers.

---
 rtl/regfile_wb_arbiter.sv | 156 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin merge of ALU and load writebacks onto the single register-file write port.
// Latency: 2 cycles from acceptance to wr_en; one write per cycle in total; WB_CONFLICT_CNT_EN adds a contention counter.
// Backpressure: x_ready drops when that requester's FIFO is full (registered state only, no pass-through).

module regfile_wb_arbiter_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         empty,
    output logic         full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt;

    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(DEPTH));
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_dat;
    end
endmodule

module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy
`ifdef WB_CONFLICT_CNT_EN
    ,
    output logic [15:0]       conflict_cnt,
    input  logic              conflict_clr
`endif
);
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_ent_t;

    wb_ent_t a_head, b_head, sel;
    logic    a_full, a_empty, b_full, b_empty;
    logic    a_push, b_push;
    logic    gnt_a, gnt_b, contested;
    logic    prefer_b;

    assign a_ready = !a_full && !reset;
    assign b_ready = !b_full && !reset;
    assign a_push  = a_valid && a_ready;
    assign b_push  = b_valid && b_ready;

    regfile_wb_arbiter_fifo #(.W(ADDR_W + DATA_W), .DEPTH(DEPTH)) u_fifo_a (
        .clk(clk), .reset(reset),
        .push(a_push), .push_dat({a_addr, a_data}),
        .pop(gnt_a), .head_dat(a_head),
        .empty(a_empty), .full(a_full)
    );

    regfile_wb_arbiter_fifo #(.W(ADDR_W + DATA_W), .DEPTH(DEPTH)) u_fifo_b (
        .clk(clk), .reset(reset),
        .push(b_push), .push_dat({b_addr, b_data}),
        .pop(gnt_b), .head_dat(b_head),
        .empty(b_empty), .full(b_full)
    );

    assign contested = !a_empty && !b_empty;

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (contested) begin
            gnt_a = !prefer_b;
            gnt_b = prefer_b;
        end else if (!a_empty) begin
            gnt_a = 1'b1;
        end else if (!b_empty) begin
            gnt_b = 1'b1;
        end
    end

    assign sel = gnt_b ? b_head : a_head;

    // r0 is hardwired zero: its entries drain through arbitration but never write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prefer_b <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            if (contested)
                prefer_b <= !prefer_b;
            wr_en <= (gnt_a || gnt_b) && (sel.addr != '0);
            if (gnt_a || gnt_b) begin
                wr_addr <= sel.addr;
                wr_data <= sel.data;
            end
        end
    end

    assign busy = !a_empty || !b_empty || wr_en;

`ifdef WB_CONFLICT_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            conflict_cnt <= '0;
        else if (conflict_clr)
            conflict_cnt <= '0;
        else if (contested && conflict_cnt != 16'hFFFF)
            conflict_cnt <= conflict_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a queue-based reference model.
module tb_regfile_wb_arbiter;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              a_valid, b_valid;
    logic              a_ready, b_ready;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DATA_W-1:0] a_data, b_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
`ifdef WB_CONFLICT_CNT_EN
    logic [15:0]       conflict_cnt;
    logic              conflict_clr = 1'b0;
`endif

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
`ifdef WB_CONFLICT_CNT_EN
        , .conflict_cnt(conflict_cnt), .conflict_clr(conflict_clr)
`endif
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t              qa[$];
    ent_t              qb[$];
    bit                m_prefer_b;
    bit                m_wr_en;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    int                m_cnt;
    bit                acc_a, acc_b;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int obs[$];
    int obs_cyc[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        m_prefer_b = 1'b0;
        m_wr_en    = 1'b0;
        m_addr     = '0;
        m_data     = '0;
        m_cnt      = 0;
        acc_a      = 1'b0;
        acc_b      = 1'b0;
    endtask

    // One clock edge of the reference: arbitrate on heads, retire, then enqueue.
    task automatic model_step();
        ent_t e;
        bit   take_a, take_b, both;
        if (reset) begin
            model_reset();
            return;
        end
        acc_a  = a_valid && (qa.size() < DEPTH);
        acc_b  = b_valid && (qb.size() < DEPTH);
        both   = (qa.size() > 0) && (qb.size() > 0);
        take_a = 1'b0;
        take_b = 1'b0;
        if (both) begin
            if (m_prefer_b) take_b = 1'b1;
            else            take_a = 1'b1;
            m_prefer_b = !m_prefer_b;
        end else if (qa.size() > 0) begin
            take_a = 1'b1;
        end else if (qb.size() > 0) begin
            take_b = 1'b1;
        end
`ifdef WB_CONFLICT_CNT_EN
        if (conflict_clr)                 m_cnt = 0;
        else if (both && m_cnt < 65535)   m_cnt = m_cnt + 1;
`endif
        if (take_a || take_b) begin
            e       = take_a ? qa.pop_front() : qb.pop_front();
            m_wr_en = (e.addr != 0);
            m_addr  = e.addr;
            m_data  = e.data;
        end else begin
            m_wr_en = 1'b0;
        end
        if (acc_a) qa.push_back('{a_addr, a_data});
        if (acc_b) qb.push_back('{b_addr, b_data});
    endtask

    task automatic check_outputs();
        chk("a_ready", a_ready, !reset && (qa.size() < DEPTH));
        chk("b_ready", b_ready, !reset && (qb.size() < DEPTH));
        chk("wr_en", wr_en, m_wr_en);
        chk("wr_addr", wr_addr, m_addr);
        chk("wr_data", wr_data, m_data);
        chk("busy", busy, (qa.size() > 0) || (qb.size() > 0) || m_wr_en);
`ifdef WB_CONFLICT_CNT_EN
        chk("conflict_cnt", conflict_cnt, m_cnt);
`endif
        if (wr_en) begin
            obs.push_back(int'(wr_addr));
            obs_cyc.push_back(cyc);
        end
        cyc++;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
    endtask

    initial begin
        int  sent_a, sent_b;
        bit  saw_a_full;
        idle_inputs();
        model_reset();

        #2;
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_wr_addr", wr_addr, '0);
        chk("rst_wr_data", wr_data, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_a_ready", a_ready, 1'b0);
        chk("rst_b_ready", b_ready, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_a_ready", a_ready, 1'b1);

        // Single A write: accepted at edge 1, visible after edge 2.
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
        step();
        idle_inputs();
        step();
        chk("t1_wr_en", wr_en, 1'b1);
        chk("t1_wr_addr", wr_addr, 5'd5);
        chk("t1_wr_data", wr_data, 32'hDEADBEEF);
        step();
        step();
        chk("t1_busy_clear", busy, 1'b0);

        // Both sides push continuously: strict A/B alternation, nothing lost.
        obs.delete(); obs_cyc.delete();
        sent_a = 0; sent_b = 0; saw_a_full = 1'b0;
        a_valid = 1'b1; a_addr = 5'd1;  a_data = $urandom;
        b_valid = 1'b1; b_addr = 5'd17; b_data = $urandom;
        for (int i = 0; i < 30; i++) begin
            step();
            if (!a_ready) saw_a_full = 1'b1;
            if (acc_a) begin
                sent_a++;
                if (sent_a < 6) begin a_addr = a_addr + 5'd1; a_data = $urandom; end
                else a_valid = 1'b0;
            end
            if (acc_b) begin
                sent_b++;
                if (sent_b < 6) begin b_addr = b_addr + 5'd1; b_data = $urandom; end
                else b_valid = 1'b0;
            end
        end
        chk("alt_count", obs.size(), 12);
        if (obs.size() == 12) begin
            for (int i = 0; i < 12; i++)
                chk("alt_order", obs[i], (i % 2 == 0) ? 1 + i / 2 : 17 + i / 2);
            chk("alt_continuous", obs_cyc[11] - obs_cyc[0], 11);
        end
        chk("alt_a_backpressure", saw_a_full, 1'b1);

        // Back-to-back A pushes with B idle retire in order.
        obs.delete(); obs_cyc.delete();
        idle_inputs();
        a_valid = 1'b1; a_addr = 5'd10; a_data = $urandom;
        sent_a = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (acc_a) begin
                sent_a++;
                if (sent_a < 3) begin a_addr = a_addr + 5'd1; a_data = $urandom; end
                else a_valid = 1'b0;
            end
        end
        chk("seq_count", obs.size(), 3);
        if (obs.size() == 3)
            for (int i = 0; i < 3; i++) chk("seq_order", obs[i], 10 + i);

        // Register 0 entry drains without a write.
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'h12345678;
        step();
        idle_inputs();
        step();
        chk("r0_wr_en", wr_en, 1'b0);
        step();
        chk("r0_busy", busy, 1'b0);

        // Asynchronous reset with work in flight.
        a_valid = 1'b1; a_addr = 5'd3;  a_data = $urandom;
        b_valid = 1'b1; b_addr = 5'd20; b_data = $urandom;
        step(); step(); step();
        chk("pre_rst_wr_en", wr_en, 1'b1);
        chk("pre_rst_busy", busy, 1'b1);
        #3;
        reset = 1'b1;
        idle_inputs();
        #1;
        chk("arst_wr_en", wr_en, 1'b0);
        chk("arst_a_ready", a_ready, 1'b0);
        chk("arst_b_ready", b_ready, 1'b0);
        chk("arst_busy", busy, 1'b0);
        model_reset();
        step();
        @(negedge clk);
        reset = 1'b0;
        obs.delete(); obs_cyc.delete();
        for (int i = 0; i < 4; i++) step();
        chk("arst_no_stale", obs.size(), 0);

`ifdef WB_CONFLICT_CNT_EN
        conflict_clr = 1'b1;
        step();
        conflict_clr = 1'b0;
        a_valid = 1'b1; a_addr = 5'd7; a_data = $urandom;
        b_valid = 1'b1; b_addr = 5'd8; b_data = $urandom;
        step();
        for (int i = 0; i < 10; i++) step();
        chk("cc_ten", conflict_cnt, 16'd10);
        conflict_clr = 1'b1;
        step();
        chk("cc_clear", conflict_cnt, 16'd0);
        conflict_clr = 1'b0;
        idle_inputs();
        for (int i = 0; i < 4; i++) step();
`endif

        // Randomized traffic; a stalled request holds until accepted.
        for (int i = 0; i < 600; i++) begin
            if (!(a_valid && !acc_a)) begin
                a_valid = ($urandom_range(0, 3) != 0);
                a_addr  = ADDR_W'($urandom_range(0, 31));
                a_data  = $urandom;
            end
            if (!(b_valid && !acc_b)) begin
                b_valid = ($urandom_range(0, 3) != 0);
                b_addr  = ADDR_W'($urandom_range(0, 31));
                b_data  = $urandom;
            end
`ifdef WB_CONFLICT_CNT_EN
            conflict_clr = ($urandom_range(0, 15) == 0);
`endif
            step();
        end
        idle_inputs();
        for (int i = 0; i < 6; i++) step();
        chk("final_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
